// File: rtl/debit_pin.sv
// Purpose : 4-digit PIN entry FSM; one-hot digits are encoded, shifted into an
//           8-bit entry register and compared with PASSKEY after every 4th digit.
// Latency : digit captured on the submit edge; verdict registered on the 4th submit edge.
// Backpressure: none, every legal submit is accepted; illegal patterns are dropped and flagged.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : synchronous, active-high
//   digit_switches : one-hot digit select (1000=3, 0100=2, 0010=1, 0001=0)
//   submit         : one-cycle strobe, registers the digit on digit_switches
//   waiting        : attempt in progress (fewer than 4 digits entered)
//   correct        : 4-digit entry matched PASSKEY
//   incorrect      : 4-digit entry differed from PASSKEY
//   bug            : sticky, illegal switch pattern submitted or illegal FSM state

// Purpose : digit encoder, legality check and entry shift register.
// Latency : password updates on the submit edge; match_o is combinational look-ahead.
// Backpressure: none.
module pin_check #(
   parameter logic [7:0] PASSKEY = 8'h0A
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [3:0] digit_switches_i,
   input  logic       submit_i,
   output logic       digit_vld_o,
   output logic       illegal_o,
   output logic       match_o
);

   logic [7:0] password;
   logic [1:0] code;
   logic       one_hot;

   always_comb begin
      code = 2'd0;
      if (digit_switches_i[3])      code = 2'd3;
      else if (digit_switches_i[2]) code = 2'd2;
      else if (digit_switches_i[1]) code = 2'd1;
   end

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   assign one_hot = (digit_switches_i != 4'd0) &&
                    ((digit_switches_i & (digit_switches_i - 4'd1)) == 4'd0);

   assign digit_vld_o = submit_i && one_hot;
   assign illegal_o   = submit_i && !one_hot;

   // Compare against the value password will hold after this digit is shifted in,
   // so the verdict lands on the same edge as the 4th digit.
   assign match_o = ({password[5:0], code} == PASSKEY);

   // Never cleared between attempts: always holds the last 4 codes, oldest in [7:6].
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         password <= 8'h00;
      end else if (digit_vld_o) begin
         password <= {password[5:0], code};
      end
   end

endmodule

module debit_pin #(
   parameter logic [7:0] PASSKEY = 8'h0A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] digit_switches,
   input  logic       submit,
   output logic       waiting,
   output logic       correct,
   output logic       incorrect,
   output logic       bug
);

   typedef enum logic [2:0] {
      ENTRY0 = 3'd0,
      ENTRY1 = 3'd1,
      ENTRY2 = 3'd2,
      ENTRY3 = 3'd3,
      RESULT = 3'd4
   } state_t;

   state_t state_q;
   logic   waiting_q;
   logic   correct_q;
   logic   incorrect_q;
   logic   bug_q;

   logic   digit_vld;
   logic   illegal;
   logic   match;

   pin_check #(.PASSKEY(PASSKEY)) pinchk (
      .clk_i            (clk),
      .reset_i          (reset),
      .digit_switches_i (digit_switches),
      .submit_i         (submit),
      .digit_vld_o      (digit_vld),
      .illegal_o        (illegal),
      .match_o          (match)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ENTRY0;
         waiting_q   <= 1'b1;
         correct_q   <= 1'b0;
         incorrect_q <= 1'b0;
         bug_q       <= 1'b0;
      end else begin
         if (illegal) bug_q <= 1'b1;

         case (state_q)
            ENTRY0: if (digit_vld) state_q <= ENTRY1;
            ENTRY1: if (digit_vld) state_q <= ENTRY2;
            ENTRY2: if (digit_vld) state_q <= ENTRY3;
            ENTRY3: begin
               if (digit_vld) begin
                  state_q     <= RESULT;
                  waiting_q   <= 1'b0;
                  correct_q   <= match;
                  incorrect_q <= !match;
               end
            end
            RESULT: begin
               // The digit that ends the result display is the first of a new attempt.
               if (digit_vld) begin
                  state_q     <= ENTRY1;
                  waiting_q   <= 1'b1;
                  correct_q   <= 1'b0;
                  incorrect_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= ENTRY0;
               waiting_q   <= 1'b1;
               correct_q   <= 1'b0;
               incorrect_q <= 1'b0;
               bug_q       <= 1'b1;
            end
         endcase
      end
   end

   assign waiting   = waiting_q;
   assign correct   = correct_q;
   assign incorrect = incorrect_q;
   assign bug       = bug_q;

endmodule

// File: tb/tb_debit_pin.sv
module tb_debit_pin;

   logic       clk;
   logic       reset;
   logic [3:0] digit_switches;
   logic       submit;
   logic       waiting;
   logic       correct;
   logic       incorrect;
   logic       bug;

   int n_checks;
   int n_fail;

   debit_pin #(.PASSKEY(8'h0A)) debitpin (
      .clk            (clk),
      .reset          (reset),
      .digit_switches (digit_switches),
      .submit         (submit),
      .waiting        (waiting),
      .correct        (correct),
      .incorrect      (incorrect),
      .bug            (bug)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic w, input logic c,
                             input logic i, input logic b, input logic [7:0] pw);
      chk({tag, ".waiting"},   {7'd0, waiting},   {7'd0, w});
      chk({tag, ".correct"},   {7'd0, correct},   {7'd0, c});
      chk({tag, ".incorrect"}, {7'd0, incorrect}, {7'd0, i});
      chk({tag, ".bug"},       {7'd0, bug},       {7'd0, b});
      chk({tag, ".password"},  debitpin.pinchk.password, pw);
   endtask

   // Drive a digit for the next rising edge; consecutive calls give back-to-back submits.
   task automatic put(input logic [3:0] sw);
      @(negedge clk);
      digit_switches = sw;
      submit         = 1'b1;
   endtask

   // Drop submit; on return the edge after the last put has passed.
   task automatic idle();
      @(negedge clk);
      submit         = 1'b0;
      digit_switches = 4'b0000;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] model;
      logic [1:0] d [4];

      n_checks       = 0;
      n_fail         = 0;
      reset          = 1'b1;
      submit         = 1'b0;
      digit_switches = 4'b0000;
      repeat (2) @(negedge clk);

      // Reset wins over a simultaneous submit.
      put(4'b1000);
      idle();
      expect_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      reset = 1'b0;

      // Correct PIN 0,0,2,2 with a mid-attempt look.
      put(4'b0001); put(4'b0001); put(4'b0100);
      idle();
      expect_out("mid3", 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
      put(4'b0100);
      idle();
      expect_out("pass", 1'b0, 1'b1, 1'b0, 1'b0, 8'h0A);

      // Wrong PIN 3,1,0,2 back-to-back.
      put(4'b1000); put(4'b0010); put(4'b0001); put(4'b0100);
      idle();
      expect_out("wrong", 1'b0, 1'b0, 1'b1, 1'b0, 8'hD2);

      // Result holds across idle cycles.
      repeat (3) @(negedge clk);
      expect_out("hold", 1'b0, 1'b0, 1'b1, 1'b0, 8'hD2);

      // One digit in RESULT starts a new attempt.
      put(4'b0010);
      idle();
      expect_out("res_next", 1'b1, 1'b0, 1'b0, 1'b0, 8'h49);

      // Second digit, then reset mid-attempt.
      put(4'b0001);
      idle();
      do_reset();
      expect_out("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      // Partial entry discarded: a full fresh attempt completes on its 4th digit.
      put(4'b0001); put(4'b0001); put(4'b0100); put(4'b0100);
      idle();
      expect_out("after_rst", 1'b0, 1'b1, 1'b0, 1'b0, 8'h0A);

      // Illegal patterns mid-attempt are dropped and flagged.
      put(4'b1000);
      idle();
      expect_out("pre_bug", 1'b1, 1'b0, 1'b0, 1'b0, 8'h2B);
      put(4'b0110);
      idle();
      expect_out("bug_0110", 1'b1, 1'b0, 1'b0, 1'b1, 8'h2B);
      put(4'b0000);
      idle();
      expect_out("bug_0000", 1'b1, 1'b0, 1'b0, 1'b1, 8'h2B);
      put(4'b0001); put(4'b0100);
      idle();
      expect_out("bug_3dig", 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2);
      put(4'b0100);
      idle();
      expect_out("bug_done", 1'b0, 1'b0, 1'b1, 1'b1, 8'hCA);

      do_reset();
      expect_out("rst_bug", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      // 24 attempts without reset; every 6th uses the real PIN.
      model = 8'h00;
      for (int a = 0; a < 24; a++) begin
         for (int k = 0; k < 4; k++) begin
            if (a % 6 == 2) d[k] = (k < 2) ? 2'd0 : 2'd2;
            else            d[k] = 2'($urandom_range(0, 3));
         end
         for (int k = 0; k < 4; k++) begin
            put(4'b0001 << d[k]);
            model = {model[5:0], d[k]};
         end
         idle();
         chk($sformatf("rand%0d.password", a), debitpin.pinchk.password, model);
         chk($sformatf("rand%0d.correct", a), {7'd0, correct},
             (model == 8'h0A) ? 8'd1 : 8'd0);
         chk($sformatf("rand%0d.incorrect", a), {7'd0, incorrect},
             (model != 8'h0A) ? 8'd1 : 8'd0);
         chk($sformatf("rand%0d.waiting", a), {7'd0, waiting}, 8'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
